// File: rtl/conv32bto10b.sv
// 32-bit to 10-bit stream width converter.
// Bits are carried MSB-first through a 41-bit shift buffer with an occupancy count.
module conv32bto10b (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vld,
    input  logic [31:0] i_dat,
    output logic        i_rdy,
    output logic        o_vld,
    output logic [9:0]  o_dat,
    input  logic        o_rdy
);
    localparam int unsigned IW = 32;
    localparam int unsigned OW = 10;
    localparam int unsigned BW = 41;
    localparam int unsigned CW = 6;

    logic [BW-1:0] buf_r;
    logic [BW-1:0] buf_nxt;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] shamt;
    logic          push;
    logic          pop;

    // Output decode from registered state; next-state for buffer and count.
    always_comb begin
        o_vld   = (cnt_r >= CW'(OW));
        i_rdy   = (cnt_r < CW'(OW)) | ((cnt_r < CW'(2 * OW)) & o_rdy);
        push    = i_vld & i_rdy;
        pop     = o_vld & o_rdy;
        shamt   = cnt_r - CW'(OW);
        o_dat   = OW'(buf_r >> shamt);
        cnt_nxt = cnt_r;
        buf_nxt = buf_r;
        if (pop) begin
            cnt_nxt = cnt_nxt - CW'(OW);
        end
        if (push) begin
            // New word enters below the presented chunk, so a stalled chunk stays put.
            cnt_nxt = cnt_nxt + CW'(IW);
            buf_nxt = {buf_r[BW-IW-1:0], i_dat};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt;
        end
    end

    // Buffer contents are only observed while the count marks them valid.
    always_ff @(posedge clk) begin
        buf_r <= buf_nxt;
    end
endmodule

// File: tb/tb_conv32bto10b.sv
// Self-checking bench for conv32bto10b against a bit-queue reference model.
module tb_conv32bto10b;
    logic        clk;
    logic        rst;
    logic        i_vld;
    logic [31:0] i_dat;
    logic        i_rdy;
    logic        o_vld;
    logic [9:0]  o_dat;
    logic        o_rdy;

    int checks;
    int errors;
    bit q[$];

    conv32bto10b dut (
        .clk  (clk),
        .rst  (rst),
        .i_vld(i_vld),
        .i_dat(i_dat),
        .i_rdy(i_rdy),
        .o_vld(o_vld),
        .o_dat(o_dat),
        .o_rdy(o_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_vld();
        return q.size() >= 10;
    endfunction

    function automatic logic m_rdy(input logic r);
        return (q.size() < 10) || ((q.size() < 20) && r);
    endfunction

    function automatic logic [9:0] m_dat();
        logic [9:0] d;
        d = '0;
        for (int i = 0; i < 10; i++) d = {d[8:0], q[i]};
        return d;
    endfunction

    // Advance one clock; model follows the stream rules on the sampled inputs.
    task automatic cycle();
        logic push, pop;
        @(posedge clk);
        push = i_vld && m_rdy(o_rdy);
        pop  = m_vld() && o_rdy;
        if (!rst) begin
            q.delete();
        end else begin
            if (pop) for (int i = 0; i < 10; i++) void'(q.pop_front());
            if (push) for (int i = 31; i >= 0; i--) q.push_back(i_dat[i]);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; i_vld = 1'b1; i_dat = 32'hDEADBEEF; o_rdy = 1'b1;
        cycle();
        rst = 1'b1; i_vld = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (o_vld !== 1'b0) begin errors++; $display("FAIL reset_o_vld got %b want 0", o_vld); end
        checks++;
        if (i_rdy !== 1'b1) begin errors++; $display("FAIL reset_i_rdy got %b want 1", i_rdy); end
    endtask

    task automatic test_single();
        logic [9:0] exp_d[3];
        exp_d[0] = 10'h2AF; exp_d[1] = 10'h0D1; exp_d[2] = 10'h08D;
        i_vld = 1'b1; i_dat = 32'hABCD1234; o_rdy = 1'b1;
        #1;
        checks++;
        if (i_rdy !== 1'b1) begin errors++; $display("FAIL single_i_rdy got %b want 1", i_rdy); end
        cycle();
        i_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (o_vld !== 1'b1 || o_dat !== exp_d[i])
                begin errors++; $display("FAIL single_chunk%0d got vld=%b dat=%h want vld=1 dat=%h", i, o_vld, o_dat, exp_d[i]); end
            cycle();
        end
        #1;
        checks++;
        if (o_vld !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", o_vld); end
    endtask

    task automatic test_carry();
        logic [9:0] exp_d[3];
        exp_d[0] = 10'h0FF; exp_d[1] = 10'h3FF; exp_d[2] = 10'h3FF;
        i_vld = 1'b1; i_dat = 32'hFFFFFFFF; o_rdy = 1'b1;
        cycle();
        i_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (o_vld !== 1'b1 || o_dat !== exp_d[i])
                begin errors++; $display("FAIL carry_chunk%0d got vld=%b dat=%h want vld=1 dat=%h", i, o_vld, o_dat, exp_d[i]); end
            cycle();
        end
        #1;
        checks++;
        if (o_vld !== 1'b0 || q.size() != 4)
            begin errors++; $display("FAIL carry_residual got vld=%b want 0 (model bits %0d want 4)", o_vld, q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[5];
        int k, n;
        bit started;
        do_reset();
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        k = 0; n = 0; started = 0;
        for (int cyc = 0; cyc < 60 && n < 16; cyc++) begin
            i_vld = (k < 5); i_dat = (k < 5) ? w[k] : 32'h0; o_rdy = 1'b1;
            #1;
            checks++;
            if (i_rdy !== m_rdy(o_rdy)) begin errors++; $display("FAIL stream_i_rdy cyc%0d got %b want %b", cyc, i_rdy, m_rdy(o_rdy)); end
            checks++;
            if (o_vld !== m_vld() || (m_vld() && o_dat !== m_dat()))
                begin errors++; $display("FAIL stream_chunk cyc%0d got vld=%b dat=%h want vld=%b dat=%h", cyc, o_vld, o_dat, m_vld(), m_dat()); end
            if (started) begin
                checks++;
                if (o_vld !== 1'b1) begin errors++; $display("FAIL stream_gap cyc%0d got o_vld=%b want 1", cyc, o_vld); end
            end
            if (o_vld === 1'b1) begin started = 1; n++; end
            if (i_vld && m_rdy(o_rdy)) k++;
            cycle();
        end
        i_vld = 1'b0;
        #1;
        checks++;
        if (n != 16 || o_vld !== 1'b0) begin errors++; $display("FAIL stream_count got %0d chunks vld=%b want 16 chunks vld=0", n, o_vld); end
    endtask

    task automatic test_backpressure();
        logic [9:0] held;
        do_reset();
        i_vld = 1'b1; i_dat = 32'h13579BDF; o_rdy = 1'b0;
        cycle();
        i_dat = 32'h2468ACE0;
        #1;
        held = o_dat;
        checks++;
        if (o_vld !== 1'b1 || i_rdy !== 1'b0 || o_dat !== m_dat())
            begin errors++; $display("FAIL bp_stall got vld=%b rdy=%b dat=%h want vld=1 rdy=0 dat=%h", o_vld, i_rdy, o_dat, m_dat()); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            #1;
            checks++;
            if (o_vld !== 1'b1 || i_rdy !== 1'b0 || o_dat !== held)
                begin errors++; $display("FAIL bp_hold%0d got vld=%b rdy=%b dat=%h want vld=1 rdy=0 dat=%h", i, o_vld, i_rdy, o_dat, held); end
        end
        o_rdy = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            checks++;
            if (i_rdy !== m_rdy(o_rdy) || o_vld !== m_vld() || (m_vld() && o_dat !== m_dat()))
                begin errors++; $display("FAIL bp_release cyc%0d got rdy=%b vld=%b dat=%h want rdy=%b vld=%b dat=%h", cyc, i_rdy, o_vld, o_dat, m_rdy(o_rdy), m_vld(), m_dat()); end
            if (i_vld && m_rdy(o_rdy)) begin cycle(); i_vld = 1'b0; end
            else cycle();
        end
        #1;
        checks++;
        if (o_vld !== 1'b0 || q.size() != 4) begin errors++; $display("FAIL bp_drain got vld=%b want 0 (model bits %0d want 4)", o_vld, q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp_d[3];
        exp_d[0] = 10'h2AF; exp_d[1] = 10'h0D1; exp_d[2] = 10'h08D;
        do_reset();
        i_vld = 1'b1; i_dat = 32'hCAFEF00D; o_rdy = 1'b0;
        cycle();
        i_vld = 1'b0; o_rdy = 1'b1;
        cycle();
        rst = 1'b0; i_vld = 1'b1; i_dat = 32'h55555555;
        cycle();
        rst = 1'b1; i_vld = 1'b0;
        #1;
        checks++;
        if (o_vld !== 1'b0 || i_rdy !== 1'b1)
            begin errors++; $display("FAIL midreset got vld=%b rdy=%b want vld=0 rdy=1", o_vld, i_rdy); end
        i_vld = 1'b1; i_dat = 32'hABCD1234;
        cycle();
        i_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (o_vld !== 1'b1 || o_dat !== exp_d[i])
                begin errors++; $display("FAIL midreset_chunk%0d got vld=%b dat=%h want vld=1 dat=%h", i, o_vld, o_dat, exp_d[i]); end
            cycle();
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!i_vld) begin
                i_vld = ($urandom_range(0, 3) != 0);
                i_dat = $urandom;
            end
            o_rdy = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (i_rdy !== m_rdy(o_rdy) || o_vld !== m_vld() || (m_vld() && o_dat !== m_dat())) begin
                errors++;
                if (bad < 5) $display("FAIL random cyc%0d got rdy=%b vld=%b dat=%h want rdy=%b vld=%b dat=%h",
                                      cyc, i_rdy, o_vld, o_dat, m_rdy(o_rdy), m_vld(), m_dat());
                bad++;
            end
            if (i_vld && m_rdy(o_rdy)) begin cycle(); i_vld = 1'b0; end
            else cycle();
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; i_vld = 1'b0; i_dat = '0; o_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_carry();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
